// File: rtl/nn_pkg.sv
// Shared definitions for the output-layer result reader.
//   DEF_* : default sizing (20 classes, 5-bit class index, 32-bit scores)
//   NO_MATCH : class code reported when no entry qualifies (all ones)
//   state_t : reader FSM encoding
package nn_pkg;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_OUTPUTS = 20;
    localparam int DEF_CLASS_W     = 5;

    localparam logic [DEF_CLASS_W-1:0] NO_MATCH = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } state_t;
endpackage

// File: rtl/nn_score_bank.sv
// Score bank: NUM_OUTPUTS registers written by one-hot strobes, a written-mask,
// and a combinational indexed read port.
//   clk, rst         : clock, async active-high reset (clears data and mask)
//   wr_en, wr_data   : every selected entry loads wr_data and sets its mask bit
//   clr              : clears the mask; a same-cycle write keeps its bit set
//   rd_idx           : read index; out-of-range reads return zero / unwritten
//   rd_data, rd_written, mask : read data, its mask bit, full mask
module nn_score_bank
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int CLASS_W     = DEF_CLASS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_OUTPUTS-1:0] wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   clr,
    input  logic [CLASS_W-1:0]     rd_idx,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_written,
    output logic [NUM_OUTPUTS-1:0] mask
);
    logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            mask <= '0;
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (wr_en[i]) begin
                    data[i] <= wr_data;
                    mask[i] <= 1'b1;
                end else if (clr) begin
                    mask[i] <= 1'b0;
                end
            end
        end
    end

    // Compare-based mux keeps the read in range for any rd_idx value.
    always_comb begin
        rd_data    = '0;
        rd_written = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (rd_idx == CLASS_W'(i)) begin
                rd_data    = data[i];
                rd_written = mask[i];
            end
        end
    end
endmodule

// File: rtl/nn_result_reader.sv
// Output-layer result reader: captures output-neuron scores, then on
// check_start scans one entry per cycle and reports the argmax class.
//   clk, rst                 : clock, async active-high reset
//   out_wr_en, out_wr_data   : one-hot score writes (dropped during SCAN)
//   check_start              : start a scan (honoured in IDLE only)
//   bank_clear               : clear the written-mask
//   busy                     : FSM not in IDLE
//   result_valid/ready       : result handshake; outputs held until accepted
//   result_class/score       : argmax index and score, or NO_MATCH / 0
//   incomplete               : mask was not full when the scan started
//   write_err                : sticky, a write arrived while scanning
// Optional NN_RESULT_RUNNER_UP_EN adds second_class and margin outputs.
module nn_result_reader
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int CLASS_W     = DEF_CLASS_W,
    parameter logic [DATA_WIDTH-1:0] MIN_CONF = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_OUTPUTS-1:0] out_wr_en,
    input  logic [DATA_WIDTH-1:0]  out_wr_data,
    input  logic                   check_start,
    input  logic                   bank_clear,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_W-1:0]     result_class,
    output logic [DATA_WIDTH-1:0]  result_score,
    output logic                   incomplete,
    output logic                   write_err
`ifdef NN_RESULT_RUNNER_UP_EN
    ,
    output logic [CLASS_W-1:0]     second_class,
    output logic [DATA_WIDTH-1:0]  margin
`endif
);
    localparam logic [CLASS_W-1:0] NONE = '1;
    localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_OUTPUTS - 1);

    state_t                  state;
    logic [CLASS_W-1:0]      idx;
    logic                    scan_last;   // all entries compared; next edge publishes
    logic [DATA_WIDTH-1:0]   best_score;
    logic [CLASS_W-1:0]      best_idx;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_written;
    logic [NUM_OUTPUTS-1:0]  mask;
    logic [NUM_OUTPUTS-1:0]  bank_wr;
    logic                    mask_clr;
    logic                    conf_ok;
    logic                    cand;
`ifdef NN_RESULT_RUNNER_UP_EN
    logic [DATA_WIDTH-1:0]   second_score;
    logic [CLASS_W-1:0]      second_idx;
`endif

    assign busy     = (state != IDLE);
    assign bank_wr  = (state == SCAN) ? '0 : out_wr_en;
    // Accepting a result frees the mask for the next utterance.
    assign mask_clr = bank_clear | ((state == RESULT) & result_ready);
    assign cand     = rd_written & (rd_data > best_score);

    // A zero threshold is always met; skip the compare so it does not fold
    // into a constant-true unsigned test.
    generate
        if (MIN_CONF == '0) begin : g_noconf
            assign conf_ok = 1'b1;
        end else begin : g_conf
            assign conf_ok = (best_score >= MIN_CONF);
        end
    endgenerate

    nn_score_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_OUTPUTS(NUM_OUTPUTS),
        .CLASS_W    (CLASS_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_wr),
        .wr_data   (out_wr_data),
        .clr       (mask_clr),
        .rd_idx    (idx),
        .rd_data   (rd_data),
        .rd_written(rd_written),
        .mask      (mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            scan_last    <= 1'b0;
            best_score   <= '0;
            best_idx     <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            incomplete   <= 1'b0;
            write_err    <= 1'b0;
`ifdef NN_RESULT_RUNNER_UP_EN
            second_score <= '0;
            second_idx   <= '0;
            second_class <= '0;
            margin       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (check_start) begin
                        state      <= SCAN;
                        incomplete <= ~&mask;
                        write_err  <= 1'b0;
                        idx        <= '0;
                        scan_last  <= 1'b0;
                        best_score <= '0;
                        best_idx   <= NONE;
`ifdef NN_RESULT_RUNNER_UP_EN
                        second_score <= '0;
                        second_idx   <= NONE;
`endif
                    end
                end
                SCAN: begin
                    if (|out_wr_en)
                        write_err <= 1'b1;
                    if (!scan_last) begin
                        // Strict compare: an equal later score never displaces
                        // the earlier index.
                        if (cand) begin
                            best_score <= rd_data;
                            best_idx   <= idx;
                        end
`ifdef NN_RESULT_RUNNER_UP_EN
                        if (cand) begin
                            second_score <= best_score;
                            second_idx   <= best_idx;
                        end else if (rd_written && rd_data > second_score) begin
                            second_score <= rd_data;
                            second_idx   <= idx;
                        end
`endif
                        if (idx == LAST)
                            scan_last <= 1'b1;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        // best_idx stays NONE unless some entry was taken.
                        if (best_idx != NONE && conf_ok) begin
                            result_class <= best_idx;
                            result_score <= best_score;
                        end else begin
                            result_class <= NONE;
                            result_score <= '0;
                        end
`ifdef NN_RESULT_RUNNER_UP_EN
                        second_class <= second_idx;
                        if (second_idx == NONE)
                            margin <= best_score;
                        else if (best_score > second_score)
                            margin <= best_score - second_score;
                        else
                            margin <= '0;
`endif
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_result_reader.sv
// Directed bench for nn_result_reader with a score-bank model and a
// scoreboard queue of expected results.
module tb_nn_result_reader;
    import nn_pkg::*;

    typedef struct {
        logic [4:0]  cls;
        logic [31:0] score;
        logic        inc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] out_wr_en = '0;
    logic [31:0] out_wr_data = '0;
    logic        check_start = 1'b0;
    logic        bank_clear = 1'b0;
    logic        busy;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [4:0]  result_class;
    logic [31:0] result_score;
    logic        incomplete;
    logic        write_err;
`ifdef NN_RESULT_RUNNER_UP_EN
    logic [4:0]  second_class;
    logic [31:0] margin;
`endif

    nn_result_reader dut (
        .clk         (clk),
        .rst         (rst),
        .out_wr_en   (out_wr_en),
        .out_wr_data (out_wr_data),
        .check_start (check_start),
        .bank_clear  (bank_clear),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_class(result_class),
        .result_score(result_score),
        .incomplete  (incomplete),
        .write_err   (write_err)
`ifdef NN_RESULT_RUNNER_UP_EN
        ,
        .second_class(second_class),
        .margin      (margin)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] bank_m [20];
    logic [19:0] mask_m = '0;
    exp_t        sb [$];
    logic [4:0]  e_cls;
    logic [31:0] e_score;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int i, input logic [31:0] v);
        out_wr_en   = 20'(1) << i;
        out_wr_data = v;
        tick();
        out_wr_en   = '0;
        bank_m[i]   = v;
        mask_m[i]   = 1'b1;
    endtask

    function automatic exp_t model_result();
        exp_t        e;
        logic [31:0] b;
        logic [4:0]  bi;
        b  = '0;
        bi = NO_MATCH;
        for (int i = 0; i < 20; i++)
            if (mask_m[i] && bank_m[i] > b) begin
                b  = bank_m[i];
                bi = 5'(i);
            end
        e.cls   = bi;
        e.score = (bi == NO_MATCH) ? '0 : b;
        e.inc   = ~&mask_m;
        return e;
    endfunction

    task automatic do_start();
        sb.push_back(model_result());
        check_start = 1'b1;
        tick();
        check_start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        while (!result_valid && cyc < 40) tick();
        chk({tag, "_latency"}, 32'(cyc), 32'd21);
        e = sb.pop_front();
        e_cls   = e.cls;
        e_score = e.score;
        chk({tag, "_class"}, 32'(result_class), 32'(e.cls));
        chk({tag, "_score"}, result_score, e.score);
        chk({tag, "_incomplete"}, 32'(incomplete), 32'(e.inc));
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        mask_m = '0;
        chk({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 20; i++) bank_m[i] = '0;
        tick();
        tick();
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_class", 32'(result_class), 32'd0);
        chk("rst_score", result_score, 32'd0);
        chk("rst_incomplete", 32'(incomplete), 32'd0);
        chk("rst_write_err", 32'(write_err), 32'd0);
        rst = 1'b0;
        tick();

        // Full bank, entry 7 dominant
        for (int i = 0; i < 20; i++) wr(i, (i == 7) ? 32'hFFFF : 32'(i * 16));
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_result("t1");
        chk("t1_class_const", 32'(result_class), 32'd7);
        accept("t1");

        // Tie between 3 and 12 goes to the lower index
        for (int i = 0; i < 20; i++) wr(i, (i == 3 || i == 12) ? 32'h500 : 32'h100);
        do_start();
        wait_result("t2");
        chk("t2_class_const", 32'(result_class), 32'd3);
        accept("t2");

        // Partial bank
        for (int i = 0; i < 10; i++) wr(i, (i == 4) ? 32'h900 : 32'(i + 1));
        do_start();
        wait_result("t3");
        chk("t3_inc_const", 32'(incomplete), 32'd1);
        accept("t3");

        // Nothing written since last accept
        do_start();
        wait_result("t4");
        chk("t4_nomatch", 32'(result_class), 32'd31);
        accept("t4");

        // Write during scan: dropped and flagged
        for (int i = 0; i < 20; i++) wr(i, (i == 5) ? 32'h7777 : 32'(i));
        do_start();
        tick();
        tick();
        out_wr_en   = 20'h00020;
        out_wr_data = 32'hDEAD_BEEF;
        tick();
        out_wr_en   = '0;
        chk("t5_write_err_set", 32'(write_err), 32'd1);
        wait_result("t5");
        chk("t5_entry5_kept", result_score, 32'h7777);
        accept("t5");
        chk("t5_write_err_sticky", 32'(write_err), 32'd1);
        for (int i = 0; i < 20; i++) wr(i, 32'(100 - i));
        do_start();
        chk("t5_write_err_clr", 32'(write_err), 32'd0);
        wait_result("t6");

        // Back-pressure with a stray check_start during RESULT
        for (int k = 0; k < 10; k++) begin
            check_start = (k == 3);
            tick();
            check_start = 1'b0;
            chk("t7_hold_valid", 32'(result_valid), 32'd1);
            chk("t7_hold_class", 32'(result_class), 32'(e_cls));
            chk("t7_hold_score", result_score, e_score);
        end
        accept("t7");
        tick();
        chk("t7_no_queued_start", 32'(busy), 32'd0);
        do_start();
        wait_result("t7_mask_cleared");
        accept("t7b");

        // Reset mid-scan
        for (int i = 0; i < 20; i++) wr(i, 32'(i * 3));
        do_start();
        while (cyc < 11) tick();
        rst = 1'b1;
        #1;
        void'(sb.pop_front());
        for (int i = 0; i < 20; i++) bank_m[i] = '0;
        mask_m = '0;
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_valid", 32'(result_valid), 32'd0);
        chk("t8_rst_class", 32'(result_class), 32'd0);
        chk("t8_rst_inc", 32'(incomplete), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) wr(i, (i == 15) ? 32'h1234_5678 : 32'(i * 2));
        do_start();
        wait_result("t8");
        chk("t8_class_const", 32'(result_class), 32'd15);
        accept("t8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nn_result_reader.md
Name: nn_result_reader

Overview:
- Read side of the output-layer register bank. The network controller writes 20 output-neuron scores using one-hot write strobes.
- This block captures those writes into a local score bank, tracks which entries have been written, and on a check request scans all entries one per cycle.
- It reports the winning class index (argmax) through a valid/ready handshake. It sits between the output layer and the recognition-result display logic.

Parameters:
- DATA_WIDTH, 32, width of each output score; unsigned fixed-point.
- NUM_OUTPUTS, 20, number of output neurons / classes.
- CLASS_W, 5, width of the class index; must satisfy 2**CLASS_W > NUM_OUTPUTS.
- MIN_CONF, 0, minimum winning score; if the maximum is below this, the result is NO_MATCH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- out_wr_en  in  NUM_OUTPUTS  one-hot write strobe; bit i writes entry i.
- out_wr_data  in  DATA_WIDTH  score to write.
- check_start  in  1  single-cycle request to begin the scan.
- bank_clear  in  1  clears the written-mask; bank data is kept.
- busy  out  1  high while SCAN or RESULT.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  downstream accepts the result.
- result_class  out  CLASS_W  winning index, or NO_MATCH (all ones).
- result_score  out  DATA_WIDTH  winning score.
- incomplete  out  1  some entries were unwritten at check_start.
- write_err  out  1  sticky; a write arrived during SCAN.

Behaviour:
- Reset: all outputs 0, state IDLE, written-mask 0, bank contents 0.
- Bank write (IDLE/RESULT): every entry whose out_wr_en bit is set loads out_wr_data on that edge, and its mask bit is set. Multiple set bits are legal; all selected entries are written.
- Bank write (SCAN): writes are dropped and write_err is set. write_err is cleared only by reset or an accepted check_start.
- bank_clear: clears the mask in any state. If it coincides with a write, the write wins for the written bit.
- State IDLE: check_start=1 → SCAN.
  - On that edge: incomplete = ~&mask, write_err cleared, scan index=0, best_score=0, best_idx=NO_MATCH.
- State SCAN: one entry per cycle, index 0..NUM_OUTPUTS-1.
  - Entry i replaces the best when score_i > best_score (strict).
  - Ties go to the lowest index.
  - An unwritten entry (mask bit 0) is skipped.
  - After index NUM_OUTPUTS-1 → RESULT.
- Result computation: result_class = best_idx if best_score >= MIN_CONF and at least one candidate was taken, else NO_MATCH. result_score = best_score, or 0 for NO_MATCH.
- Latency: result_valid rises exactly NUM_OUTPUTS+1 rising edges after the edge that sampled check_start (21 with defaults).
- State RESULT: result_valid=1, and the result outputs are stable.
  - On result_valid & result_ready → IDLE, with result_valid=0 on the next cycle.
  - The mask is cleared on that edge, ready for the next utterance.
- check_start outside IDLE is ignored; no queuing.
- busy = (state != IDLE).
- Scan counter width is CLASS_W; it never wraps past NUM_OUTPUTS-1.
- Reset asserted mid-scan or mid-result aborts immediately to the reset values.

Optional Feature:
- NN_RESULT_RUNNER_UP_EN defined: adds outputs second_class (CLASS_W) and margin (DATA_WIDTH).
  - The scan tracks the second-best entry with the same tie rule.
  - margin = best_score - second_score, saturating at 0.
  - If fewer than 2 candidates, second_class = NO_MATCH and margin = best_score.
  - Both outputs are valid alongside result_valid.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg: NUM_OUTPUTS, CLASS_W, NO_MATCH constant, state encoding (IDLE=0, SCAN=1, RESULT=2).
- One sub-module, nn_score_bank: NUM_OUTPUTS x DATA_WIDTH registers, one-hot write, mask tracking, indexed combinational read.
- FSM and compare logic stay in nn_result_reader.

Test Plan:
- Write all 20 entries with score=i*16, entry 7 = 0xFFFF, then check_start → result_valid at edge +21, class=7, score=0xFFFF, incomplete=0.
- Entries 3 and 12 both 0x500 and the rest 0x100 → class=3 (lowest-index tie).
- Write only entries 0..9 with entry 4 largest → incomplete=1, class=4; with no writes → class=NO_MATCH (31), score=0.
- Pulse out_wr_en[5] during SCAN → write_err=1, entry 5 unchanged, result unaffected; a next accepted check_start clears write_err.
- Hold result_ready=0 for 10 cycles → result_valid and outputs stable; raise ready → IDLE next cycle, mask cleared. A check_start during RESULT is ignored.
- Assert rst at scan index 10 → all outputs 0, IDLE; a new full run then returns the correct class.
